spi_reg_ctrl: RTL and testbench
===============================

Name: spi_reg_ctrl

Overview:
Frame-level controller for the 8-bit SPI receive path. It consumes received bytes plus the raw chip-select, and decodes each CS-low frame as one command byte followed by data bytes. Data bytes are written into a local configuration register bank with address auto-increment. The bank is exported as a flat bus that configures downstream fabric logic.

Parameters:
NUM_REGS, 16, number of 8-bit config registers; legal range 1..128
RESET_VAL, 8'h00, reset value of every register

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  received byte; valid only when rx_valid=1
rx_valid  in  1  single-cycle pulse per received byte, synchronous to clk
cs  in  1  raw SPI chip-select, active-low, asynchronous to clk
regs_flat  out  NUM_REGS*8  register bank; reg i at bits [8*i+7:8*i]
wr_strobe  out  1  1-cycle pulse on each register write
wr_addr  out  7  address written on the wr_strobe cycle
frame_done  out  1  1-cycle pulse at the end of a frame that performed at least one write
err_cnt  out  8  saturating count of errored frames
busy  out  1  high while the state is not IDLE

Behaviour:
- Reset is asynchronous and active-low on rst_n. The block has one clock, clk.
- Reset values: every register = RESET_VAL; wr_strobe=0, wr_addr=0, frame_done=0, err_cnt=0, busy=0; state=IDLE. The cs synchronizer resets to 2'b11 (deasserted).
- cs is passed through a 2-FF synchronizer. cs_fall and cs_rise are single-cycle pulses taken from the synchronized value.
- States: IDLE, CMD, DATA, DISCARD.
- IDLE:
  - rx_valid is ignored.
  - cs_fall -> CMD. The wrote flag is cleared.
- CMD, on rx_valid:
  - cmd = rx_data; bit7 = write flag W; bits[6:0] = start address A.
  - W=0: the frame is a no-op, with no error -> DISCARD.
  - W=1 and A < NUM_REGS: ptr <= A -> DATA.
  - W=1 and A >= NUM_REGS: the frame is errored -> DISCARD.
- DATA, on rx_valid:
  - reg[ptr] <= rx_data; wr_strobe=1 and wr_addr=ptr on the next cycle; wrote flag set.
  - If ptr == NUM_REGS-1, the next byte overruns the bank: the frame is errored -> DISCARD. The pointer does not wrap.
  - Otherwise ptr <= ptr+1.
- DISCARD: rx_valid is ignored until the frame ends.
- End of frame:
  - cs_rise in any non-IDLE state -> IDLE.
  - frame_done pulses on the following cycle if the wrote flag is set.
  - An errored frame increments err_cnt once; err_cnt saturates at 8'hFF.
- Latency: rx_valid at cycle t -> register value, wr_strobe and wr_addr visible at t+1.
- rx_valid and cs_rise in the same cycle: the byte is processed first under the current state, then the state goes to IDLE. frame_done reflects the byte written in that cycle.
- cs_fall while not IDLE (glitch, or a missed cs_rise): restart at CMD. The previous frame is closed silently, with no frame_done and no err_cnt change.
- A frame with CS low but no bytes: no write, no frame_done, no error.
- Reset mid-frame: all state clears. Bytes are ignored until the next cs_fall.
- regs_flat is driven directly from the registers, with no extra pipeline stage.

Decomposition:
- Shared package spi_reg_pkg holds:
  - state encoding constants: IDLE=2'd0, CMD=2'd1, DATA=2'd2, DISCARD=2'd3
  - CMD_W_BIT=7
  - CMD_ADDR_MSB=6
  - ERR_CNT_MAX=8'hFF
- One sub-module, spi_cs_sync: the 2-FF synchronizer plus rise/fall pulse detect. It has async active-low reset to 2'b11 and is reusable for other async SPI pins.

Test Plan:
- Write burst: CS low; bytes 8'h83, 8'hAA, 8'h55; CS high -> reg3=AA and reg4=55. wr_strobe pulses twice with wr_addr 3 then 4. frame_done pulses once; err_cnt=0.
- Overrun: command 8'h8F (NUM_REGS=16), then bytes 11, 22 -> reg15=11 and no other register changes. err_cnt=1; frame_done=1.
- Bad address: command 8'h90, then byte 77 -> no wr_strobe and no frame_done; err_cnt=1.
- No-op and empty frames: command 8'h05 plus byte 99, then a CS pulse with no bytes -> registers unchanged, no frame_done, err_cnt unchanged.
- Collision and reset: rx_valid on the same cycle as cs_rise in DATA -> the byte is written and frame_done asserts. Assert rst_n=0 mid-frame -> all registers return to RESET_VAL, and bytes before the next CS fall are ignored.
- Saturation: force 256 errored frames -> err_cnt stays at 8'hFF.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI configuration-register controller.
// The command byte carries a write flag in bit 7 and a start address in bits 6:0.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        DATA    = 2'd2,
        DISCARD = 2'd3
    } state_e;

    localparam int          CMD_W_BIT    = 7;
    localparam int          CMD_ADDR_MSB = 6;
    localparam logic [7:0]  ERR_CNT_MAX  = 8'hFF;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == ERR_CNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/spi_cs_sync.sv
// Two-flop synchronizer for an asynchronous, active-low SPI pin.
// It resets to the deasserted level and emits single-cycle edge pulses taken from the synchronized value.
module spi_cs_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], async_i};
            prev_q <= sync_q[1];
        end
    end

    assign rise_o =  sync_q[1] & ~prev_q;
    assign fall_o = ~sync_q[1] &  prev_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// Frame decoder for the SPI receive path. Each CS-low frame is one command byte followed by data bytes,
// which are written into an auto-incrementing configuration register bank.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int         NUM_REGS  = 16,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic                  cs,
    output logic [NUM_REGS*8-1:0] regs_flat,
    output logic                  wr_strobe,
    output logic [6:0]            wr_addr,
    output logic                  frame_done,
    output logic [7:0]            err_cnt,
    output logic                  busy
);

    localparam logic [7:0] NREGS     = 8'(NUM_REGS);
    localparam logic [6:0] LAST_ADDR = 7'(NUM_REGS - 1);

    state_e                     state_q;
    logic [6:0]                 ptr_q;
    logic                       wrote_q;
    logic                       err_q;
    logic [NUM_REGS-1:0][7:0]   regs_q;
    logic                       wr_strobe_q;
    logic [6:0]                 wr_addr_q;
    logic                       frame_done_q;
    logic [7:0]                 err_cnt_q;

    logic       cs_rise, cs_fall;
    logic       cmd_w;
    logic [6:0] cmd_addr;
    logic       addr_ok;
    logic       do_write;
    logic       bad_addr;
    logic       overrun;
    logic       wrote_nx;
    logic       err_nx;

    spi_cs_sync u_cs_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (cs),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    // Effects of the byte in this cycle; folded into the frame flags even when cs_rise
    // closes the frame on the same edge, so a colliding last byte still counts.
    always_comb begin
        cmd_w    = rx_data[CMD_W_BIT];
        cmd_addr = rx_data[CMD_ADDR_MSB:0];
        addr_ok  = ({1'b0, cmd_addr} < NREGS);
        do_write = (state_q == DATA) && rx_valid && !cs_fall;
        bad_addr = (state_q == CMD) && rx_valid && !cs_fall && cmd_w && !addr_ok;
        overrun  = do_write && (ptr_q == LAST_ADDR);
        wrote_nx = wrote_q | do_write;
        err_nx   = err_q | bad_addr | overrun;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            wrote_q      <= 1'b0;
            err_q        <= 1'b0;
            regs_q       <= {NUM_REGS{RESET_VAL}};
            wr_strobe_q  <= 1'b0;
            wr_addr_q    <= '0;
            frame_done_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            wr_strobe_q  <= do_write;
            frame_done_q <= 1'b0;

            for (int i = 0; i < NUM_REGS; i++) begin
                if (do_write && ptr_q == 7'(i)) regs_q[i] <= rx_data;
            end
            if (do_write) wr_addr_q <= ptr_q;

            // A fall while a frame is open abandons it without reporting anything.
            if (cs_fall) begin
                state_q <= CMD;
                wrote_q <= 1'b0;
                err_q   <= 1'b0;
            end else if (state_q != IDLE) begin
                if (cs_rise) begin
                    state_q      <= IDLE;
                    frame_done_q <= wrote_nx;
                    wrote_q      <= 1'b0;
                    err_q        <= 1'b0;
                    if (err_nx) err_cnt_q <= sat_inc(err_cnt_q);
                end else begin
                    wrote_q <= wrote_nx;
                    err_q   <= err_nx;
                    case (state_q)
                        CMD: begin
                            if (rx_valid) begin
                                if (cmd_w && addr_ok) begin
                                    ptr_q   <= cmd_addr;
                                    state_q <= DATA;
                                end else begin
                                    state_q <= DISCARD;
                                end
                            end
                        end
                        DATA: begin
                            if (rx_valid) begin
                                if (ptr_q == LAST_ADDR) state_q <= DISCARD;
                                else                    ptr_q   <= ptr_q + 7'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign regs_flat  = regs_q;
    assign wr_strobe  = wr_strobe_q;
    assign wr_addr    = wr_addr_q;
    assign frame_done = frame_done_q;
    assign err_cnt    = err_cnt_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: write bursts, overrun, bad address, no-op/empty frames,
// cs_rise collision, mid-frame reset and error-counter saturation.
module tb_spi_reg_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         cs;
    logic [127:0] regs_flat;
    logic         wr_strobe;
    logic [6:0]   wr_addr;
    logic         frame_done;
    logic [7:0]   err_cnt;
    logic         busy;

    int vectors = 0;
    int miscompares = 0;

    int         strobe_cnt = 0;
    int         done_cnt   = 0;
    logic [6:0] last_addr  = '0;
    logic [6:0] prev_addr  = '0;
    int         s_base, d_base;

    logic [7:0] exp_regs [16];

    spi_reg_ctrl #(.NUM_REGS(16), .RESET_VAL(8'h00)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .cs         (cs),
        .regs_flat  (regs_flat),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .frame_done (frame_done),
        .err_cnt    (err_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe) begin
            strobe_cnt <= strobe_cnt + 1;
            prev_addr  <= last_addr;
            last_addr  <= wr_addr;
        end
        if (frame_done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] exp_flat();
        logic [127:0] f;
        for (int i = 0; i < 16; i++) f[8*i +: 8] = exp_regs[i];
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
    endtask

    task automatic cs_low();
        cs = 1'b0;
        repeat (4) tick();
    endtask

    task automatic cs_high();
        cs = 1'b1;
        repeat (4) tick();
    endtask

    task automatic mark();
        s_base = strobe_cnt;
        d_base = done_cnt;
    endtask

    initial begin
        rst_n    = 1'b0;
        cs       = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
        repeat (3) tick();

        chk("rst_regs",      regs_flat,  exp_flat());
        chk("rst_strobe",    wr_strobe,  0);
        chk("rst_addr",      wr_addr,    0);
        chk("rst_done",      frame_done, 0);
        chk("rst_err",       err_cnt,    0);
        chk("rst_busy",      busy,       0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Write burst 83, AA, 55
        mark();
        cs_low();
        chk("burst_busy", busy, 1);
        send_byte(8'h83);
        rx_data  = 8'hAA;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        chk("lat_reg3",    regs_flat[31:24], 8'hAA);
        chk("lat_strobe",  wr_strobe,        1);
        chk("lat_addr",    wr_addr,          3);
        tick();
        send_byte(8'h55);
        cs_high();
        exp_regs[3] = 8'hAA;
        exp_regs[4] = 8'h55;
        chk("burst_regs",   regs_flat,           exp_flat());
        chk("burst_nstrb",  strobe_cnt - s_base, 2);
        chk("burst_addr0",  prev_addr,           3);
        chk("burst_addr1",  last_addr,           4);
        chk("burst_done",   done_cnt - d_base,   1);
        chk("burst_err",    err_cnt,             0);
        chk("burst_idle",   busy,                0);

        // Overrun at last register
        mark();
        cs_low();
        send_byte(8'h8F);
        send_byte(8'h11);
        send_byte(8'h22);
        cs_high();
        exp_regs[15] = 8'h11;
        chk("ovr_regs",  regs_flat,           exp_flat());
        chk("ovr_nstrb", strobe_cnt - s_base, 1);
        chk("ovr_addr",  last_addr,           15);
        chk("ovr_done",  done_cnt - d_base,   1);
        chk("ovr_err",   err_cnt,             1);

        // Bad start address
        mark();
        cs_low();
        send_byte(8'h90);
        send_byte(8'h77);
        cs_high();
        chk("bad_regs",  regs_flat,           exp_flat());
        chk("bad_nstrb", strobe_cnt - s_base, 0);
        chk("bad_done",  done_cnt - d_base,   0);
        chk("bad_err",   err_cnt,             2);

        // No-op command, then an empty frame
        mark();
        cs_low();
        send_byte(8'h05);
        send_byte(8'h99);
        cs_high();
        cs_low();
        cs_high();
        chk("nop_regs",  regs_flat,           exp_flat());
        chk("nop_nstrb", strobe_cnt - s_base, 0);
        chk("nop_done",  done_cnt - d_base,   0);
        chk("nop_err",   err_cnt,             2);

        // Last byte lands on the same edge as cs_rise
        mark();
        cs_low();
        send_byte(8'h82);
        cs = 1'b1;
        tick();
        tick();
        chk("col_busy_pre", busy, 1);
        rx_data  = 8'h5A;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        exp_regs[2] = 8'h5A;
        chk("col_reg2",   regs_flat[23:16], 8'h5A);
        chk("col_strobe", wr_strobe,        1);
        chk("col_done",   frame_done,       1);
        chk("col_busy",   busy,             0);
        repeat (3) tick();
        chk("col_ndone",  done_cnt - d_base, 1);
        chk("col_err",    err_cnt,           2);

        // Reset in the middle of a frame
        cs_low();
        send_byte(8'h81);
        send_byte(8'h33);
        rst_n = 1'b0;
        cs    = 1'b1;
        #2;
        for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
        chk("mrst_regs", regs_flat, exp_flat());
        chk("mrst_err",  err_cnt,   0);
        chk("mrst_busy", busy,      0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        mark();
        send_byte(8'h84);
        send_byte(8'h44);
        chk("mrst_ign_regs",  regs_flat,           exp_flat());
        chk("mrst_ign_nstrb", strobe_cnt - s_base, 0);
        chk("mrst_ign_busy",  busy,                0);
        cs_low();
        send_byte(8'h84);
        send_byte(8'h44);
        cs_high();
        exp_regs[4] = 8'h44;
        chk("mrst_recover", regs_flat, exp_flat());

        // Error counter saturation
        for (int n = 0; n < 254; n++) begin
            cs_low();
            send_byte(8'h90);
            cs_high();
        end
        chk("sat_254", err_cnt, 8'hFE);
        for (int n = 0; n < 2; n++) begin
            cs_low();
            send_byte(8'hFF);
            cs_high();
        end
        chk("sat_ff", err_cnt, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
